// File: rtl/inv_sqrt_poly_eval.sv
// inv_sqrt_poly_eval: 4-stage c0 + c1*dx + c2*dx^2 evaluator
// for the SFU inverse-square-root path.
module inv_sqrt_poly_eval (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [23:0]        in_x,
  output logic [11:0]        lut_x_msb,
  input  logic signed [28:0] lut_c0,
  input  logic signed [24:0] lut_c1,
  input  logic signed [16:0] lut_c2,
  input  logic signed [13:0] lut_a,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [23:0]        out_y,
  output logic               out_err
);

  typedef struct packed {
    logic [28:0] c0;
    logic [24:0] c1;
    logic [16:0] c2;
    logic [19:0] dx;
    logic        err;
  } s0_t;

  typedef struct packed {
    logic [28:0] c0;
    logic [16:0] c2;
    logic [16:0] sq;
    logic [29:0] p1;
    logic        err;
  } s1_t;

  typedef struct packed {
    logic [29:0] s;
    logic [29:0] p2;
    logic        err;
  } s2_t;

  logic en;
  logic v0, v1, v2, v3;
  s0_t  s0_d, s0_q;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  logic signed [24:0] dx_full;
  logic signed [39:0] dx_sq;
  logic signed [44:0] c1_dx;
  logic signed [34:0] c2_sq;
  logic signed [31:0] t;
  logic signed [31:0] r;
  logic signed [28:0] y_full;
  logic [23:0]        y_d;

  assign en        = out_ready | ~v3;
  assign in_ready  = en;
  assign lut_x_msb = in_x[23:12];
  assign out_valid = v3;

  always_comb begin
    // midpoint a is Q3.11, in_x is Q2.22
    dx_full = $signed({1'b0, in_x})
            - $signed({lut_a, 11'b0});
    s0_d.c0  = lut_c0;
    s0_d.c1  = lut_c1;
    s0_d.c2  = lut_c2;
    s0_d.dx  = 20'(dx_full);
    s0_d.err = ~|in_x[23:22];
  end

  always_comb begin
    dx_sq = 40'($signed(s0_q.dx))
          * 40'($signed(s0_q.dx));
    c1_dx = 45'($signed(s0_q.c1))
          * 45'($signed(s0_q.dx));
    s1_d.c0  = s0_q.c0;
    s1_d.c2  = s0_q.c2;
    s1_d.sq  = 17'(dx_sq >> 22);
    s1_d.p1  = 30'(c1_dx >>> 18);
    s1_d.err = s0_q.err;
  end

  always_comb begin
    c2_sq = 35'($signed(s1_q.c2))
          * $signed(35'(s1_q.sq));
    s2_d.p2  = 30'(c2_sq >>> 12);
    s2_d.s   = 30'($signed(s1_q.c0))
             + $signed(s1_q.p1);
    s2_d.err = s1_q.err;
  end

  always_comb begin
    t = 32'($signed(s2_q.s))
      + 32'($signed(s2_q.p2));
    r = t + 32'sd4;
    y_full = 29'(r >>> 3);
    if (s2_q.err || y_full < 29'sd0)
      y_d = 24'h0;
    else if (y_full > 29'sd16777215)
      y_d = 24'hFFFFFF;
    else
      y_d = y_full[23:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0      <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      s0_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      out_y   <= 24'h0;
      out_err <= 1'b0;
    end else if (en) begin
      v0 <= in_valid;
      v1 <= v0;
      v2 <= v1;
      v3 <= v2;
      if (in_valid) s0_q <= s0_d;
      if (v0)       s1_q <= s1_d;
      if (v1)       s2_q <= s2_d;
      // bubbles must present zeros on the output
      if (v2) begin
        out_y   <= y_d;
        out_err <= s2_q.err;
      end else begin
        out_y   <= 24'h0;
        out_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inv_sqrt_poly_eval.sv
// tb_inv_sqrt_poly_eval: directed + streamed checks against
// a real-valued x^-0.5 model with a Taylor-coefficient LUT.
module tb_inv_sqrt_poly_eval;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [23:0]        in_x = 24'h0;
  logic [11:0]        lut_x_msb;
  logic signed [28:0] lut_c0;
  logic signed [24:0] lut_c1;
  logic signed [16:0] lut_c2;
  logic signed [13:0] lut_a;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [23:0]        out_y;
  logic               out_err;

  inv_sqrt_poly_eval dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .lut_x_msb(lut_x_msb),
    .lut_c0(lut_c0), .lut_c1(lut_c1),
    .lut_c2(lut_c2), .lut_a(lut_a),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit rmode = 1'b0;

  always @(posedge clk) cyc++;

  function automatic void chk(input bit ok, input string nm,
                              input logic [31:0] got,
                              input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endfunction

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  // Taylor expansion of m^-0.5 around each segment midpoint
  int  lk;
  real lm, lf;
  always_comb begin
    lk = int'(lut_x_msb);
    lm = real'(2 * lk + 1) / 2048.0;
    lf = 1.0 / $sqrt(lm);
    lut_a = 14'(2 * lk + 1);
    if (lk < 1024) begin
      lut_c0 = '0;
      lut_c1 = '0;
      lut_c2 = '0;
    end else begin
      lut_c0 = 29'(rnd(lf * 67108864.0));
      lut_c1 = 25'(rnd(-0.5 * lf * lf * lf * 4194304.0));
      lut_c2 = 17'(rnd(0.375 * lf * lf * lf * lf * lf * 65536.0));
    end
  end

  function automatic int model_y(input logic [23:0] x);
    real v;
    int  y;
    v = 8388608.0 / $sqrt(real'(x) / 4194304.0);
    y = rnd(v);
    if (y > 32'hFFFFFF) y = 32'hFFFFFF;
    return y;
  endfunction

  logic [23:0] xq[$];
  int          nout = 0;
  int          mark = 0;
  int          first_oc = 0;
  int          last_oc = 0;
  bit          prev_stall = 1'b0;
  logic [23:0] prev_y = '0;
  logic        prev_err = 1'b0;

  always @(negedge clk) begin
    logic [23:0] x;
    int          e, d;
    if (rst) begin
      xq.delete();
      prev_stall = 1'b0;
    end else begin
      chk(in_ready == !(out_valid && !out_ready), "in_ready",
          in_ready, !(out_valid && !out_ready));
      if (!out_valid)
        chk(out_y == 0 && out_err == 0, "idle_out",
            {out_err, out_y}, 0);
      if (prev_stall)
        chk(out_valid && out_y == prev_y && out_err == prev_err,
            "stall_hold", {out_err, out_y}, {prev_err, prev_y});
      if (out_valid && out_ready) begin
        chk(xq.size() != 0, "spurious_out", out_y, 0);
        if (xq.size() != 0) begin
          x = xq.pop_front();
          if (nout == mark) first_oc = cyc;
          last_oc = cyc;
          nout++;
          if (x < 24'h400000) begin
            chk(out_err && out_y == 0, "err_out",
                {out_err, out_y}, 32'h1000000);
          end else begin
            e = model_y(x);
            d = int'(out_y) - e;
            chk(!out_err && d >= -4 && d <= 4, "y_model",
                {out_err, out_y}, e);
          end
        end
      end
      if (in_valid && in_ready) xq.push_back(in_x);
      prev_stall = out_valid && !out_ready;
      prev_y     = out_y;
      prev_err   = out_err;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input logic [23:0] x);
    int n = 0;
    in_valid = 1'b1;
    in_x     = x;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(n < 200, "accept_timeout", n, 200);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int c);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(out_valid, "out_timeout", n, 50);
    c = cyc;
  endtask

  task automatic single(input logic [23:0] x, input int ey,
                        input bit eerr, input string nm);
    int c, d;
    send(x);
    in_valid = 1'b0;
    wait_out(c);
    chk(c - acc_cyc == 4, {nm, "_lat"}, c - acc_cyc, 4);
    d = int'(out_y) - ey;
    chk(out_err == eerr && d >= -4 && d <= 4, nm,
        {out_err, out_y}, {eerr, 24'(ey)});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (xq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(xq.size() == 0, nm, xq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c, n;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, n, seen;
    // model pins
    chk(model_y(24'h400000) == 32'h800000, "pin_1p0",
        model_y(24'h400000), 32'h800000);
    n = model_y(24'h800000) - 32'h5A8279;
    chk(n >= -1 && n <= 1, "pin_2p0", model_y(24'h800000), 32'h5A8279);
    n = model_y(24'hFFFFFF) - 32'h400000;
    chk(n >= -1 && n <= 1, "pin_4m", model_y(24'hFFFFFF), 32'h400000);

    #12;
    chk(!out_valid && out_y == 0 && out_err == 0, "reset_state",
        {out_valid, out_err, out_y}, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk(in_ready, "ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    single(24'h400000, 32'h800000, 1'b0, "x_1p0");
    single(24'h800000, 32'h5A8279, 1'b0, "x_2p0");
    single(24'hFFFFFF, 32'h400000, 1'b0, "x_max");

    // out-of-range then in-range
    send(24'h3FFFFF);
    send(24'h400000);
    in_valid = 1'b0;
    wait_out(c);
    chk(c - acc_cyc == 3, "err_lat", c - acc_cyc, 3);
    chk(out_err && out_y == 0, "err_lit", {out_err, out_y}, 32'h1000000);
    @(negedge clk);
    n = int'(out_y) - 32'h800000;
    chk(out_valid && !out_err && n >= -4 && n <= 4, "after_err",
        {out_valid, out_err, out_y}, 32'h2800000);
    @(posedge clk);
    #1;

    // back-to-back stream, no bubbles
    mark = nout;
    for (int i = 0; i < 64; i++)
      send(24'($urandom_range(24'hFFFFFF, 24'h400000)));
    in_valid = 1'b0;
    drain("stream_drain");
    chk(nout - mark == 64, "stream_count", nout - mark, 64);
    chk(last_oc - first_oc == 63, "stream_bubbles",
        last_oc - first_oc, 63);

    // stream under random backpressure
    mark  = nout;
    rmode = 1'b1;
    for (int i = 0; i < 64; i++)
      send(24'($urandom_range(24'hFFFFFF, 24'h400000)));
    in_valid = 1'b0;
    rmode    = 1'b0;
    drain("bp_drain");
    chk(nout - mark == 64, "bp_count", nout - mark, 64);

    // reset with three operands in flight
    send(24'h500000);
    send(24'h900000);
    send(24'hC00000);
    in_valid = 1'b0;
    wait_out(c);
    #2 rst = 1'b1;
    #1 chk(!out_valid && out_y == 0 && out_err == 0, "async_rst",
           {out_valid, out_err, out_y}, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk(seen == 0, "no_stale", seen, 0);
    @(posedge clk);
    #1;
    single(24'hFFFFFF, 32'h400000, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
